// File: rtl/m_n_counter.sv
// Modulo-N up/down counter with clamped parallel load, wrap or bounce stepping, one-hot decode and cascade TC.
// Latency: load and count take effect on the next rising i_cp; no backpressure, i_en gates every step.
module m_n_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic               i_cp,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_pe,
    input  logic               i_dir,
    input  logic               i_mode,
    input  logic [WIDTH-1:0]   i_d,
    output logic [WIDTH-1:0]   o_q,
    output logic [MODULUS-1:0] o_onehot,
    output logic               o_tc,
    output logic               o_up
);

    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    logic [WIDTH-1:0]   r_cnt;
    logic               r_bdir;
    logic [WIDTH-1:0]   w_cnt_nxt;
    logic               w_bdir_nxt;
    logic               w_up;
    logic               w_at_max;
    logic               w_at_zero;
    logic [MODULUS-1:0] w_onehot;

    assign w_up      = i_mode ? r_bdir : i_dir;
    assign w_at_max  = (r_cnt == C_MAX);
    assign w_at_zero = (r_cnt == C_ZERO);

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_bdir_nxt = r_bdir;
        if (i_pe) begin
            w_cnt_nxt  = (i_d > C_MAX) ? C_MAX : i_d;
            w_bdir_nxt = i_dir;
        end else if (i_en) begin
            if (!i_mode) begin
                w_bdir_nxt = i_dir;
                if (i_dir) begin
                    w_cnt_nxt = w_at_max ? C_ZERO : r_cnt + C_ONE;
                end else begin
                    w_cnt_nxt = w_at_zero ? C_MAX : r_cnt - C_ONE;
                end
            end else if (r_bdir) begin
                // Turn around at the top: endpoint is shown once, then we head back down.
                if (w_at_max) begin
                    w_cnt_nxt  = r_cnt - C_ONE;
                    w_bdir_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end else begin
                if (w_at_zero) begin
                    w_cnt_nxt  = C_ONE;
                    w_bdir_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_cp or posedge i_clr) begin
        if (i_clr) begin
            r_cnt  <= '0;
            r_bdir <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_bdir <= w_bdir_nxt;
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < MODULUS; i++) begin
            w_onehot[i] = (r_cnt == WIDTH'(i));
        end
    end

    assign o_q      = r_cnt;
    assign o_onehot = w_onehot;
    assign o_up     = w_up;
    // Combinational so a downstream stage steps on the same edge this stage wraps.
    assign o_tc     = i_en & ~i_mode & ((w_up & w_at_max) | (~w_up & w_at_zero));

endmodule

// File: tb/tb_m_n_counter.sv
// Directed bench for m_n_counter: reset, wrap, load/clamp, bounce and a two-stage decade cascade.
module tb_m_n_counter;

    logic cp, clr;
    int n_cmp, n_err;

    logic       a_en, a_pe, a_dir, a_mode;
    logic [3:0] a_d, a_q;
    logic [15:0] a_oh;
    logic       a_tc, a_up;

    logic       b_en, b_pe, b_dir, b_mode;
    logic [3:0] b_d, b_q;
    logic [9:0] b_oh;
    logic       b_tc, b_up;

    logic       c_en, c_pe, c_dir, c_mode;
    logic [1:0] c_d, c_q;
    logic [3:0] c_oh;
    logic       c_tc, c_up;

    logic       e_en, e_pe, e_dir, e_mode;
    logic [3:0] e_d, lo_q, hi_q;
    logic [9:0] lo_oh, hi_oh;
    logic       lo_tc, lo_up, hi_tc, hi_up;

    m_n_counter #(.WIDTH(4), .MODULUS(16)) u_a (
        .i_cp(cp), .i_clr(clr), .i_en(a_en), .i_pe(a_pe), .i_dir(a_dir), .i_mode(a_mode),
        .i_d(a_d), .o_q(a_q), .o_onehot(a_oh), .o_tc(a_tc), .o_up(a_up));

    m_n_counter #(.WIDTH(4), .MODULUS(10)) u_b (
        .i_cp(cp), .i_clr(clr), .i_en(b_en), .i_pe(b_pe), .i_dir(b_dir), .i_mode(b_mode),
        .i_d(b_d), .o_q(b_q), .o_onehot(b_oh), .o_tc(b_tc), .o_up(b_up));

    m_n_counter #(.WIDTH(2), .MODULUS(4)) u_c (
        .i_cp(cp), .i_clr(clr), .i_en(c_en), .i_pe(c_pe), .i_dir(c_dir), .i_mode(c_mode),
        .i_d(c_d), .o_q(c_q), .o_onehot(c_oh), .o_tc(c_tc), .o_up(c_up));

    m_n_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .i_cp(cp), .i_clr(clr), .i_en(e_en), .i_pe(e_pe), .i_dir(e_dir), .i_mode(e_mode),
        .i_d(e_d), .o_q(lo_q), .o_onehot(lo_oh), .o_tc(lo_tc), .o_up(lo_up));

    m_n_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .i_cp(cp), .i_clr(clr), .i_en(lo_tc), .i_pe(e_pe), .i_dir(e_dir), .i_mode(e_mode),
        .i_d(e_d), .o_q(hi_q), .o_onehot(hi_oh), .o_tc(hi_tc), .o_up(hi_up));

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    initial begin
        int lo_m, hi_m;
        logic [1:0] bq_exp [7];
        logic       bu_exp [7];
        n_cmp = 0;
        n_err = 0;
        clr = 1'b1;
        a_en = 1'b1; a_pe = 1'b0; a_dir = 1'b0; a_mode = 1'b0; a_d = '0;
        b_en = 1'b0; b_pe = 1'b0; b_dir = 1'b1; b_mode = 1'b0; b_d = '0;
        c_en = 1'b0; c_pe = 1'b0; c_dir = 1'b0; c_mode = 1'b1; c_d = '0;
        e_en = 1'b0; e_pe = 1'b0; e_dir = 1'b1; e_mode = 1'b0; e_d = '0;
        #1;
        check_val("rst_q", a_q, 0);
        check_val("rst_oh", a_oh, 16'h0001);
        check_val("rst_tc_down", a_tc, 1);
        check_val("rst_up_wrap", a_up, 0);
        check_val("rst_up_bounce", c_up, 1);
        a_dir = 1'b1;
        #1;
        check_val("rst_tc_up", a_tc, 0);
        #2 clr = 1'b0;

        // Count to 7, then pulse clear between edges.
        for (int k = 1; k <= 7; k++) tick();
        check_val("pre_clr_q", a_q, 7);
        #2 clr = 1'b1;
        #1;
        check_val("async_clr_q", a_q, 0);
        check_val("async_clr_oh", a_oh, 16'h0001);
        a_en = 1'b0;
        #1 clr = 1'b0;
        tick();
        check_val("hold_after_clr", a_q, 0);

        a_en = 1'b1; a_dir = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check_val("wrap_q", a_q, k % 16);
            check_val("wrap_tc", a_tc, (k % 16) == 15);
            check_val("wrap_oh", a_oh, 32'(1) << (k % 16));
        end

        a_pe = 1'b1; a_d = 4'd9;
        tick();
        check_val("load_q", a_q, 9);
        a_pe = 1'b0; a_dir = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_val("down_q", a_q, (9 - k + 16) % 16);
            check_val("down_tc", a_tc, ((9 - k + 16) % 16) == 0);
        end
        a_en = 1'b0; a_pe = 1'b1; a_d = 4'd9;
        #1;
        check_val("tc_en_low", a_tc, 0);
        tick();
        check_val("load_noen_q", a_q, 9);
        a_pe = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_val("hold_q", a_q, 9);
        check_val("hold_oh", a_oh, 16'h0200);

        // Clamp on a modulus-10 counter.
        b_pe = 1'b1; b_d = 4'd13;
        tick();
        check_val("clamp_q", b_q, 9);
        check_val("clamp_oh", b_oh, 10'h200);
        b_pe = 1'b0; b_en = 1'b1;
        #1;
        check_val("clamp_tc", b_tc, 1);
        tick();
        check_val("clamp_wrap_q", b_q, 0);
        b_dir = 1'b0;
        tick();
        check_val("m10_down_wrap", b_q, 9);
        b_en = 1'b0;

        // Bounce mode on modulus 4; DIR is ignored while counting.
        bq_exp = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        bu_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        c_en = 1'b1;
        check_val("bounce_q0", c_q, 0);
        for (int k = 0; k < 7; k++) begin
            tick();
            check_val("bounce_q", c_q, bq_exp[k]);
            check_val("bounce_up", c_up, bu_exp[k]);
            check_val("bounce_tc", c_tc, 0);
        end
        c_pe = 1'b1; c_d = 2'd2; c_dir = 1'b0;
        tick();
        check_val("bounce_load_q", c_q, 2);
        check_val("bounce_load_up", c_up, 0);
        c_pe = 1'b0;
        tick();
        check_val("bounce_seed_q", c_q, 1);
        c_en = 1'b0;

        // Two-decade cascade.
        lo_m = 0; hi_m = 0;
        e_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            check_val("casc_lo_tc", lo_tc, lo_m == 9);
            tick();
            if (lo_m == 9) hi_m = (hi_m + 1) % 10;
            lo_m = (lo_m + 1) % 10;
            check_val("casc_lo", lo_q, lo_m);
            check_val("casc_hi", hi_q, hi_m);
            if (k == 99) check_val("casc_99", 32'(hi_q) * 10 + 32'(lo_q), 99);
        end
        check_val("casc_00", 32'(hi_q) * 10 + 32'(lo_q), 0);
        e_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m_n_counter.md
# m_n_counter

Parametrised modulo-N up/down counter with synchronous parallel load, terminal-count output and one-hot decoded output. It succeeds the fixed 16-state counter/decoder: the modulus and width are now parameters, and a bounce (ping-pong) mode is added. It drives running-light and sequencer displays on the experiment board. Its terminal-count output lets several instances cascade on one clock.

## Interface
- `WIDTH`, 4: count register width in bits; must satisfy 2^WIDTH >= `MODULUS`.
- `MODULUS`, 16: number of states, 2..2^WIDTH; count range is 0..`MODULUS`-1.

- `CP`, in, 1: clock; all state changes on the rising edge.
- `CLR`, in, 1: reset, asynchronous, active-high.
- `EN`, in, 1: count enable; also serves as the cascade input from the previous stage's `TC`.
- `PE`, in, 1: synchronous parallel load, active-high.
- `DIR`, in, 1: direction, 1 = up, 0 = down; in bounce mode it only seeds the direction on load.
- `MODE`, in, 1: 0 = wrap mode, 1 = bounce mode.
- `D`, in, `WIDTH`: parallel load value.
- `Q`, out, `WIDTH`: current count, registered.
- `ONEHOT`, out, `MODULUS`: decoded count; bit `Q` is high and all other bits are low.
- `TC`, out, 1: terminal count, combinational.
- `UP`, out, 1: effective direction currently in use, registered in bounce mode.

## Operation
- State consists of the count register `cnt` and the bounce direction register `bdir`.
- Effective direction:
  - Wrap mode: `DIR`.
  - Bounce mode: `bdir`.
  - `UP` always shows the effective direction.
- Priority on each rising `CP`: `CLR` > `PE` > `EN` > hold.
- **Load** (`PE`=1, independent of `EN`):
  - `cnt` <= `D` if `D` < `MODULUS`, otherwise `MODULUS`-1 (clamp).
  - `bdir` <= `DIR`.
- **Count, wrap mode** (`EN`=1, `PE`=0):
  - Up: +1, `MODULUS`-1 -> 0.
  - Down: -1, 0 -> `MODULUS`-1.
  - `bdir` tracks `DIR`.
- **Count, bounce mode** (`EN`=1, `PE`=0):
  - Up: +1; at `MODULUS`-1 the step goes to `MODULUS`-2 and `bdir` becomes 0.
  - Down: -1; at 0 the step goes to 1 and `bdir` becomes 1.
  - Endpoints are each held for exactly one count, with no repeated value.
  - With `MODULUS`=2 the counter alternates 0,1,0,1.
- **`TC`** = `EN` & (`MODE`=0) & ((`UP` & `cnt`==`MODULUS`-1) | (!`UP` & `cnt`==0)).
  - `TC` is never asserted in bounce mode.
  - `TC` is asserted while `PE`=1 if the above terms hold, so cascades must load all stages together.
- **Mode switching:** changing `MODE` mid-count takes effect on the next edge. Entering bounce mode keeps `bdir` at the last `DIR`.
- **Arithmetic:** all arithmetic is in `WIDTH` bits with explicit wrap compare against `MODULUS`-1. `cnt` never holds a value >= `MODULUS`.

## Timing
- Reset values while `CLR`=1, effective immediately and asynchronously:
  - `Q`=0, `bdir`=1.
  - `ONEHOT`=1 (bit 0 set).
  - `UP`=`DIR` in wrap mode, 1 in bounce mode.
  - `TC`=`EN` & !`MODE` & !`DIR`.
- `CLR` deasserted: the first change occurs on the next rising `CP` after release.
- `CLR` asserted mid-count or mid-load: the pending load/count is discarded and no partial update occurs.
- Latency:
  - Load: 1 cycle; `Q`=`D` after the edge that samples `PE`=1.
  - Count: 1 cycle per edge.
  - `ONEHOT` is decoded combinationally from the `Q` register, zero extra latency, glitch-free with respect to `Q`.
- `EN`=0 and `PE`=0: `Q`, `bdir` and `ONEHOT` hold indefinitely.
- Cascade: the lower stage's `TC` feeds the upper stage's `EN` on the same `CP`. The upper stage steps on the same edge on which the lower stage wraps.

## Test plan
- **Reset:** `MODULUS`=16. Pulse `CLR` mid-cycle while `Q`=7 -> `Q`=0 and `ONEHOT`=16'h0001 immediately, before the next edge.
- **Wrap up:** `EN`=1, `DIR`=1, `MODE`=0 for 17 edges from 0 -> `Q` goes 1..15 then 0.
  - `TC`=1 only during the cycle with `Q`=15.
  - `ONEHOT`=16'h8000 at `Q`=15.
- **Load then down:** `PE`=1 with `D`=9 for one edge, then `DIR`=0 -> `Q` goes 9, 8, ..., 0, 15.
  - `TC`=1 at `Q`=0.
  - A load while `EN`=0 still gives `Q`=9.
- **Clamp:** `MODULUS`=10, `WIDTH`=4, `PE`=1 with `D`=13 -> `Q`=9. A following up count -> `Q`=0.
- **Bounce:** `MODE`=1, `MODULUS`=4, `EN`=1 from reset -> `Q` sequence 0,1,2,3,2,1,0,1.
  - `UP` drops on the edge leaving 3.
  - `TC` stays 0 throughout.
- **Cascade:** two `MODULUS`=10 instances, the low stage's `TC` driving the high stage's `EN`, counting up 100 edges from 0 -> the pair reads 99 then 00.
  - The high stage steps only on edges where the low stage reads 9.
